// File: rtl/pattern_detect_ctrl.sv
// P-stage register and sequencing control for the DSP slice pattern detector:
// detect capture with past copies, overflow/underflow decode, auto-reset FSM and match counter.
module pattern_detect_ctrl #(
    parameter int unsigned AUTORESET_MODE  = 0,
    parameter int unsigned SEL_PATTERN_CFG = 1,
    parameter int unsigned SEL_MASK_CFG    = 1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CEP,
    input  logic             RSTP,
    input  logic             PD_IN,
    input  logic             PDB_IN,
    input  logic             CNT_CLR,
    output logic             SEL_PATTERN,
    output logic             SEL_MASK,
    output logic             PATTERNDETECT,
    output logic             PATTERNBDETECT,
    output logic             PATTERNDETECTPAST,
    output logic             PATTERNBDETECTPAST,
    output logic             OVERFLOW,
    output logic             UNDERFLOW,
    output logic             AUTORESET_P,
    output logic [CNT_W-1:0] MATCH_COUNT
);

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        ARMED   = 2'd1,
        AUTORST = 2'd2
    } state_t;

    // Modes 3 and above fall back to no auto-reset.
    localparam bit MODE_MATCH = (AUTORESET_MODE == 1);
    localparam bit MODE_FALL  = (AUTORESET_MODE == 2);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic             autorst_q;
    logic             pd_q, pdb_q, pd_past_q, pdb_past_q;
    logic [CNT_W-1:0] cnt_q;

    // Pulse bit is registered alongside the state so AUTORESET_P has no decode glitches.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= MONITOR;
            autorst_q <= 1'b0;
        end else begin
            autorst_q <= 1'b0;
            if (RSTP) begin
                state <= MONITOR;
            end else begin
                case (state)
                    MONITOR: begin
                        if (CEP && PD_IN && MODE_MATCH) begin
                            state     <= AUTORST;
                            autorst_q <= 1'b1;
                        end else if (CEP && PD_IN && MODE_FALL) begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (CEP && !PD_IN) begin
                            state     <= AUTORST;
                            autorst_q <= 1'b1;
                        end
                    end
                    AUTORST: state <= MONITOR;
                    default: state <= MONITOR;
                endcase
            end
        end
    end

    // Leaving AUTORST mirrors the P-register clear so no stale past bits remain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pd_q       <= 1'b0;
            pdb_q      <= 1'b0;
            pd_past_q  <= 1'b0;
            pdb_past_q <= 1'b0;
        end else if (RSTP || state == AUTORST) begin
            pd_q       <= 1'b0;
            pdb_q      <= 1'b0;
            pd_past_q  <= 1'b0;
            pdb_past_q <= 1'b0;
        end else if (CEP) begin
            pd_q       <= PD_IN;
            pdb_q      <= PDB_IN;
            pd_past_q  <= pd_q;
            pdb_past_q <= pdb_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (CNT_CLR) begin
            cnt_q <= '0;
        end else if (CEP && PD_IN && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign SEL_PATTERN        = (SEL_PATTERN_CFG != 0);
    assign SEL_MASK           = (SEL_MASK_CFG != 0);
    assign PATTERNDETECT      = pd_q;
    assign PATTERNBDETECT     = pdb_q;
    assign PATTERNDETECTPAST  = pd_past_q;
    assign PATTERNBDETECTPAST = pdb_past_q;
    assign OVERFLOW           = pd_past_q  & ~pd_q & ~pdb_q;
    assign UNDERFLOW          = pdb_past_q & ~pd_q & ~pdb_q;
    assign AUTORESET_P        = autorst_q;
    assign MATCH_COUNT        = cnt_q;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Scoreboard bench for pattern_detect_ctrl: four instances (modes 0/1/2 and a 4-bit counter)
// share stimulus; expected flag vectors are queued and a monitor compares them.
module tb_pattern_detect_ctrl;

    logic CLK, RST_N, CEP, RSTP, PD_IN, PDB_IN, CNT_CLR;

    // Flag layout: {SEL_PATTERN, SEL_MASK, PD, PDB, PDPAST, PDBPAST, OVF, UNF, AUTORESET_P}
    logic [8:0]  f0, f1, f2, f3;
    logic [15:0] c0, c1, c2;
    logic [3:0]  c3;

    typedef struct {
        string       name;
        int unsigned dut;
        logic [8:0]  flags;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    event mon_kick;

    pattern_detect_ctrl #(.AUTORESET_MODE(0)) u0 (
        .CLK(CLK), .RST_N(RST_N), .CEP(CEP), .RSTP(RSTP), .PD_IN(PD_IN), .PDB_IN(PDB_IN),
        .CNT_CLR(CNT_CLR), .SEL_PATTERN(f0[8]), .SEL_MASK(f0[7]), .PATTERNDETECT(f0[6]),
        .PATTERNBDETECT(f0[5]), .PATTERNDETECTPAST(f0[4]), .PATTERNBDETECTPAST(f0[3]),
        .OVERFLOW(f0[2]), .UNDERFLOW(f0[1]), .AUTORESET_P(f0[0]), .MATCH_COUNT(c0));

    pattern_detect_ctrl #(.AUTORESET_MODE(1)) u1 (
        .CLK(CLK), .RST_N(RST_N), .CEP(CEP), .RSTP(RSTP), .PD_IN(PD_IN), .PDB_IN(PDB_IN),
        .CNT_CLR(CNT_CLR), .SEL_PATTERN(f1[8]), .SEL_MASK(f1[7]), .PATTERNDETECT(f1[6]),
        .PATTERNBDETECT(f1[5]), .PATTERNDETECTPAST(f1[4]), .PATTERNBDETECTPAST(f1[3]),
        .OVERFLOW(f1[2]), .UNDERFLOW(f1[1]), .AUTORESET_P(f1[0]), .MATCH_COUNT(c1));

    pattern_detect_ctrl #(.AUTORESET_MODE(2)) u2 (
        .CLK(CLK), .RST_N(RST_N), .CEP(CEP), .RSTP(RSTP), .PD_IN(PD_IN), .PDB_IN(PDB_IN),
        .CNT_CLR(CNT_CLR), .SEL_PATTERN(f2[8]), .SEL_MASK(f2[7]), .PATTERNDETECT(f2[6]),
        .PATTERNBDETECT(f2[5]), .PATTERNDETECTPAST(f2[4]), .PATTERNBDETECTPAST(f2[3]),
        .OVERFLOW(f2[2]), .UNDERFLOW(f2[1]), .AUTORESET_P(f2[0]), .MATCH_COUNT(c2));

    pattern_detect_ctrl #(.AUTORESET_MODE(0), .SEL_PATTERN_CFG(0), .SEL_MASK_CFG(0), .CNT_W(4)) u3 (
        .CLK(CLK), .RST_N(RST_N), .CEP(CEP), .RSTP(RSTP), .PD_IN(PD_IN), .PDB_IN(PDB_IN),
        .CNT_CLR(CNT_CLR), .SEL_PATTERN(f3[8]), .SEL_MASK(f3[7]), .PATTERNDETECT(f3[6]),
        .PATTERNBDETECT(f3[5]), .PATTERNDETECTPAST(f3[4]), .PATTERNBDETECTPAST(f3[3]),
        .OVERFLOW(f3[2]), .UNDERFLOW(f3[1]), .AUTORESET_P(f3[0]), .MATCH_COUNT(c3));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [8:0] act_flags(input int unsigned d);
        case (d)
            0:       return f0;
            1:       return f1;
            2:       return f2;
            default: return f3;
        endcase
    endfunction

    function automatic logic [15:0] act_cnt(input int unsigned d);
        case (d)
            0:       return c0;
            1:       return c1;
            2:       return c2;
            default: return {12'd0, c3};
        endcase
    endfunction

    // Monitor: drains the scoreboard on every falling edge or on demand.
    initial begin
        forever begin
            @(negedge CLK or mon_kick);
            while (sb.size() > 0) begin
                exp_t e;
                logic [8:0]  af;
                logic [15:0] ac;
                e  = sb.pop_front();
                af = act_flags(e.dut);
                ac = act_cnt(e.dut);
                compared++;
                if (af !== e.flags || ac !== e.cnt) begin
                    mismatched++;
                    $display("FAIL %s u%0d: flags=%b cnt=%0d, required flags=%b cnt=%0d",
                             e.name, e.dut, af, ac, e.flags, e.cnt);
                end
            end
        end
    end

    task automatic expect_o(input string n, input int unsigned d,
                            input logic [8:0] f, input logic [15:0] c);
        sb.push_back('{name: n, dut: d, flags: f, cnt: c});
    endtask

    task automatic step(input logic cep, input logic pd, input logic pdb,
                        input logic rstp, input logic clr);
        @(negedge CLK);
        CEP = cep; PD_IN = pd; PDB_IN = pdb; RSTP = rstp; CNT_CLR = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        CEP = 1'b0; PD_IN = 1'b0; PDB_IN = 1'b0; RSTP = 1'b0; CNT_CLR = 1'b0;
        @(negedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0;
        CEP = 1'b0; PD_IN = 1'b0; PDB_IN = 1'b0; RSTP = 1'b0; CNT_CLR = 1'b0;
        #2;
        expect_o("reset_m0", 0, 9'b11_0000_00_0, 16'd0);
        expect_o("reset_m1", 1, 9'b11_0000_00_0, 16'd0);
        expect_o("reset_m2", 2, 9'b11_0000_00_0, 16'd0);
        expect_o("reset_sel0", 3, 9'b00_0000_00_0, 16'd0);
        @(negedge CLK);
        #1;
        RST_N = 1'b1;

        // Overflow sequence in mode 0
        step(1, 1, 0, 0, 0); expect_o("ovf_e1", 0, 9'b11_1000_00_0, 16'd1);
        step(1, 1, 0, 0, 0); expect_o("ovf_e2", 0, 9'b11_1010_00_0, 16'd2);
        step(1, 0, 0, 0, 0); expect_o("ovf_e3", 0, 9'b11_0010_10_0, 16'd2);
        expect_o("ovf_e3_sel0", 3, 9'b00_0010_10_0, 16'd2);

        // Underflow sequence in mode 0
        do_reset();
        step(1, 0, 1, 0, 0); expect_o("unf_e1", 0, 9'b11_0100_00_0, 16'd0);
        step(1, 0, 0, 0, 0); expect_o("unf_e2", 0, 9'b11_0001_01_0, 16'd0);

        // Both detects together
        step(1, 1, 1, 0, 0); expect_o("both_e1", 0, 9'b11_1100_00_0, 16'd1);

        // Mode 1 reset on match
        do_reset();
        step(1, 1, 0, 0, 0); expect_o("m1_pulse", 1, 9'b11_1000_00_1, 16'd1);
        step(1, 0, 0, 0, 0); expect_o("m1_clear", 1, 9'b11_0000_00_0, 16'd1);
        step(1, 0, 0, 0, 0); expect_o("m1_no_ovf", 1, 9'b11_0000_00_0, 16'd1);

        // Mode 2 reset on falling edge of match
        do_reset();
        step(1, 0, 0, 0, 0); expect_o("m2_e1", 2, 9'b11_0000_00_0, 16'd0);
        step(1, 1, 0, 0, 0); expect_o("m2_e2", 2, 9'b11_1000_00_0, 16'd1);
        step(1, 1, 0, 0, 0); expect_o("m2_e3", 2, 9'b11_1010_00_0, 16'd2);
        step(1, 1, 0, 0, 0); expect_o("m2_e4", 2, 9'b11_1010_00_0, 16'd3);
        step(1, 0, 0, 0, 0); expect_o("m2_pulse", 2, 9'b11_0010_10_1, 16'd3);
        step(1, 0, 0, 0, 0); expect_o("m2_clear", 2, 9'b11_0000_00_0, 16'd3);

        // CEP low holds the detect registers and the counter
        do_reset();
        step(1, 1, 0, 0, 0); expect_o("cep_load", 0, 9'b11_1000_00_0, 16'd1);
        step(0, 0, 0, 0, 0); expect_o("cep_hold1", 0, 9'b11_1000_00_0, 16'd1);
        step(0, 1, 0, 0, 0); expect_o("cep_hold2", 0, 9'b11_1000_00_0, 16'd1);
        step(0, 0, 1, 0, 0); expect_o("cep_hold3", 0, 9'b11_1000_00_0, 16'd1);

        // RSTP while ARMED aborts the pending pulse
        do_reset();
        step(1, 1, 0, 0, 0); expect_o("rstp_armed", 2, 9'b11_1000_00_0, 16'd1);
        step(0, 0, 0, 1, 0); expect_o("rstp_clear", 2, 9'b11_0000_00_0, 16'd1);
        step(1, 0, 0, 0, 0); expect_o("rstp_no_pulse", 2, 9'b11_0000_00_0, 16'd1);

        // RSTP with capture: counter still increments; RSTP during AUTORST
        do_reset();
        step(1, 1, 0, 1, 0); expect_o("rstp_cap_m0", 0, 9'b11_0000_00_0, 16'd1);
        expect_o("rstp_cap_m1", 1, 9'b11_0000_00_0, 16'd1);
        step(1, 1, 0, 0, 0); expect_o("rstp_ar_pulse", 1, 9'b11_1000_00_1, 16'd2);
        step(1, 1, 0, 1, 0); expect_o("rstp_in_ar", 1, 9'b11_0000_00_0, 16'd3);
        step(0, 0, 0, 0, 0); expect_o("rstp_ar_after", 1, 9'b11_0000_00_0, 16'd3);

        // Counter saturation and clear
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0, 0);
            if (i == 14) expect_o("sat_reach", 3, 9'b00_1010_00_0, 16'd15);
        end
        expect_o("sat_hold", 3, 9'b00_1010_00_0, 16'd15);
        expect_o("cnt16_20", 0, 9'b11_1010_00_0, 16'd20);
        step(1, 1, 0, 0, 1); expect_o("clr_prio", 3, 9'b00_1010_00_0, 16'd0);
        expect_o("clr_prio16", 0, 9'b11_1010_00_0, 16'd0);
        step(1, 1, 0, 0, 0); expect_o("clr_resume", 3, 9'b00_1010_00_0, 16'd1);

        // Asynchronous reset during AUTORST
        do_reset();
        step(1, 1, 0, 0, 0); expect_o("async_pre", 1, 9'b11_1000_00_1, 16'd1);
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        expect_o("async_m1", 1, 9'b11_0000_00_0, 16'd0);
        expect_o("async_m0", 0, 9'b11_0000_00_0, 16'd0);
        -> mon_kick;
        #1;
        @(negedge CLK);
        #1;
        RST_N = 1'b1;

        @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pattern_detect_ctrl.md
Name: pattern_detect_ctrl

Overview:
- Sequencing and register stage for the DSP slice pattern detector.
- Samples the combinational PATTERN_DETECT / PATTERNB_DETECT results into the P-stage timing and keeps the previous-cycle ("past") copies.
- Derives OVERFLOW / UNDERFLOW from the current and past copies.
- Runs the auto-reset state machine that pulses the P-register reset on a match or on the end of a match. It also drives the pattern and mask source selects and counts matches.

Parameters:
- AUTORESET_MODE, 0, auto-reset policy: 0 = none, 1 = reset on match, 2 = reset on not-match (falling edge of match). Values 3 and above behave as 0.
- SEL_PATTERN_CFG, 1, value driven on SEL_PATTERN: 1 = fixed pattern, 0 = C.
- SEL_MASK_CFG, 1, value driven on SEL_MASK: 1 = fixed mask, 0 = C.
- CNT_W, 16, width of the match counter.

Ports:
- CLK  in  1  slice clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CEP  in  1  P-stage clock enable.
- RSTP  in  1  synchronous P-stage reset, active-high.
- PD_IN  in  1  combinational PATTERN_DETECT from the detector.
- PDB_IN  in  1  combinational PATTERNB_DETECT from the detector.
- CNT_CLR  in  1  synchronous clear of MATCH_COUNT.
- SEL_PATTERN  out  1  pattern source select to the detector.
- SEL_MASK  out  1  mask source select to the detector.
- PATTERNDETECT  out  1  registered PD_IN.
- PATTERNBDETECT  out  1  registered PDB_IN.
- PATTERNDETECTPAST  out  1  PATTERNDETECT delayed one CEP edge.
- PATTERNBDETECTPAST  out  1  PATTERNBDETECT delayed one CEP edge.
- OVERFLOW  out  1  PATTERNDETECTPAST & ~PATTERNDETECT & ~PATTERNBDETECT.
- UNDERFLOW  out  1  PATTERNBDETECTPAST & ~PATTERNDETECT & ~PATTERNBDETECT.
- AUTORESET_P  out  1  one-cycle reset pulse to the P register.
- MATCH_COUNT  out  CNT_W  saturating count of captured matches.

Behaviour:
- Reset: RST_N=0 immediately clears every register: all detect, past, counter and FSM state. All outputs go to 0, except SEL_PATTERN and SEL_MASK, which are constant and equal to their _CFG parameters.
- Capture: on a CEP=1 edge:
  - PATTERNDETECT<=PD_IN and PATTERNBDETECT<=PDB_IN.
  - PATTERNDETECTPAST<=PATTERNDETECT and PATTERNBDETECTPAST<=PATTERNBDETECT (old values).
  - Latency from PD_IN to PATTERNDETECT is 1 edge.
  - With CEP=0, all four detect registers hold.
- OVERFLOW and UNDERFLOW are combinational from the registered outputs. They assert for as long as that register combination holds.
- FSM states: MONITOR, ARMED, AUTORST.
  - MONITOR, mode 1: CEP=1 and PD_IN=1 -> AUTORST.
  - MONITOR, mode 2: CEP=1 and PD_IN=1 -> ARMED.
  - MONITOR, mode 0: the FSM stays in MONITOR permanently.
  - ARMED (mode 2 only): CEP=1 and PD_IN=0 -> AUTORST; otherwise stay.
  - AUTORST -> MONITOR on the next edge, unconditionally (not CEP-gated).
  - AUTORESET_P = (state==AUTORST), decoded from state, glitch-free.
- Effect of AUTORST: the edge that leaves AUTORST clears all four detect registers regardless of CEP. This mirrors the P register being cleared, so no false OVERFLOW/UNDERFLOW follows an auto-reset.
- RSTP=1 at an edge:
  - Clears all four detect registers and returns the FSM to MONITOR, regardless of CEP.
  - Leaves MATCH_COUNT unchanged.
  - Has priority over capture and over FSM transitions.
  - RSTP during AUTORST forces MONITOR; the pulse still lasts exactly 1 cycle.
- Counter:
  - Increments by 1 on each CEP=1 edge with PD_IN=1.
  - Saturates at 2^CNT_W-1.
  - CNT_CLR=1 clears it and has priority over increment.
  - Not affected by RSTP or auto-reset.
- PD_IN=PDB_IN=1 together is legal (e.g. full mask). Both registers capture 1; OVERFLOW=UNDERFLOW=0.
- Mid-operation RST_N assertion aborts any pending auto-reset pulse at once.

Test Plan:
- Mode 0, CEP=1, PD_IN sequence 1,1,0 with PDB_IN=0 -> PATTERNDETECT 1,1,0. After the third edge, PATTERNDETECTPAST=1 and OVERFLOW=1. AUTORESET_P stays 0. MATCH_COUNT=2.
- Mode 0, PDB_IN 1 then 0 with PD_IN=0 -> after the second edge, UNDERFLOW=1 and OVERFLOW=0.
- Mode 1, PD_IN=1 for one CEP edge -> AUTORESET_P=1 for exactly the next cycle. After that cycle, all detect outputs are 0 and OVERFLOW stays 0.
- Mode 2, PD_IN 0,1,1,1,0 on CEP edges -> AUTORESET_P pulses once, the cycle after the edge sampling the final 0. No pulse occurs while PD_IN is held at 1.
- CEP=0 with PD_IN toggling -> all detect registers hold and MATCH_COUNT is unchanged.
- RSTP:
  - RSTP=1 while in ARMED -> FSM returns to MONITOR and no pulse follows.
  - RSTP=1 together with CEP=1, PD_IN=1 -> PATTERNDETECT=0 and MATCH_COUNT still increments.
- Counter saturation:
  - CNT_W=4 with 20 match edges -> MATCH_COUNT=15.
  - CNT_CLR=1 together with a match -> MATCH_COUNT=0.
- Async reset: RST_N pulled low during AUTORST -> AUTORESET_P drops immediately and all outputs are 0.
